serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/full_adder_bit.sv | 30 +++
 rtl/half_adder.sv | 12 +
 rtl/serial_adder.sv | 94 +++++++++
 tb/tb_serial_adder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encodings.
package adder_defs;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder made from two half adders with the carries ORed together.
module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic carry_i,
  output logic sum_o,
  output logic carry_o
);

  logic partSum;
  logic partCarry;
  logic finalCarry;

  half_adder firstHalf (
    .a_i     (a_i),
    .b_i     (b_i),
    .sum_o   (partSum),
    .carry_o (partCarry)
  );

  half_adder secondHalf (
    .a_i     (partSum),
    .b_i     (carry_i),
    .sum_o   (sum_o),
    .carry_o (finalCarry)
  );

  assign carry_o = partCarry | finalCarry;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder, the building block for the per-bit full adder.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts two operands, adds one bit per cycle LSB first,
// then holds the sum and carry until the consumer takes them.
module serial_adder
  import adder_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opB_q, result_q;
  logic [WIDTH-1:0] resultShift;
  logic [CW-1:0]    count_q;
  logic             carry_q;
  logic             bitSum, bitCarry;
  logic             accept;

  full_adder_bit bitAdder (
    .a_i     (opA_q[0]),
    .b_i     (opB_q[0]),
    .carry_i (carry_q),
    .sum_o   (bitSum),
    .carry_o (bitCarry)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)         state_d = ADD;
      ADD:     if (count_q == LAST)  state_d = DONE;
      DONE:    if (out_ready)        state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == ADD);
    out_valid = (state_q == DONE);
  end

  assign accept = in_valid && in_ready;

  // New sum bit enters at the MSB so the LSB-first result lands aligned after WIDTH shifts.
  always_comb begin
    resultShift             = result_q >> 1;
    resultShift[WIDTH-1]    = bitSum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opA_q    <= '0;
      opB_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
    end else if (accept) begin
      opA_q    <= ip1;
      opB_q    <= ip2;
      result_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
    end else if (state_q == ADD) begin
      opA_q    <= opA_q >> 1;
      opB_q    <= opB_q >> 1;
      result_q <= resultShift;
      carry_q  <= bitCarry;
      count_q  <= count_q + CW'(1);
    end
  end

  assign sum   = result_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed scenarios on an 8-bit instance plus randomized
// traffic on 8-bit and 1-bit instances, checked by a queue-based scoreboard.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v8, r8, ov8, or8, c8, busy8;
  logic [7:0] a8, b8, s8;
  logic       v1, r1, ov1, or1, c1, busy1;
  logic [0:0] a1, b1, s1;

  int         checks = 0;
  int         failures = 0;
  logic [8:0] exp8Q[$];
  logic [1:0] exp1Q[$];
  logic [8:0] e8;
  logic [1:0] e1;
  bit         randMode = 1'b0;
  int         waitsA, waitsB, cyc;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .ip1(a8), .ip2(b8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .carry(c8), .busy(busy8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .ip1(a1), .ip2(b1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .carry(c1), .busy(busy1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flagFailure(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got timeout/unexpected expected normal completion", name);
  endtask

  // Scoreboard: expected {carry,sum} pushed at accept, popped and compared at consume.
  always @(negedge clk) begin
    if (rst) begin
      exp8Q.delete();
      exp1Q.delete();
    end else begin
      if (ov8 && or8) begin
        if (exp8Q.size() == 0) flagFailure("w8 result without operands");
        else begin
          e8 = exp8Q.pop_front();
          checkOutput("w8 result", {23'b0, c8, s8}, {23'b0, e8});
        end
      end
      if (v8 && r8) exp8Q.push_back({1'b0, a8} + {1'b0, b8});
      if (ov1 && or1) begin
        if (exp1Q.size() == 0) flagFailure("w1 result without operands");
        else begin
          e1 = exp1Q.pop_front();
          checkOutput("w1 result", {30'b0, c1, s1}, {30'b0, e1});
        end
      end
      if (v1 && r1) exp1Q.push_back({1'b0, a1} + {1'b0, b1});
    end
  end

  always @(posedge clk) begin
    if (randMode) begin
      #1;
      or8 = 1'($urandom_range(0, 1));
      or1 = 1'($urandom_range(0, 1));
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, output int waits);
    v8 = 1'b1; a8 = a; b8 = b; waits = 0;
    while (!r8 && waits < 100) begin
      tick();
      waits++;
    end
    if (r8) tick();
    else flagFailure("w8 accept wait");
    v8 = 1'b0;
  endtask

  task automatic applyStimulus1(input logic [0:0] a, input logic [0:0] b, output int waits);
    v1 = 1'b1; a1 = a; b1 = b; waits = 0;
    while (!r1 && waits < 100) begin
      tick();
      waits++;
    end
    if (r1) tick();
    else flagFailure("w1 accept wait");
    v1 = 1'b0;
  endtask

  task automatic waitResult(output int cycles);
    cycles = 1;
    while (!ov8 && cycles < 100) begin
      tick();
      cycles++;
    end
    if (!ov8) flagFailure("w8 result wait");
  endtask

  initial begin
    rst = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
    v1 = 1'b0; a1 = '0; b1 = '0; or1 = 1'b1;
    repeat (3) tick();
    checkOutput("reset in_ready", {31'b0, r8}, 32'd1);
    checkOutput("reset out_valid", {31'b0, ov8}, 32'd0);
    checkOutput("reset busy", {31'b0, busy8}, 32'd0);
    checkOutput("reset sum/carry", {23'b0, c8, s8}, 32'd0);
    checkOutput("reset w1 outputs", {28'b0, r1, ov1, c1, s1}, 32'h8);
    rst = 1'b0;

    // (a) basic add and latency
    applyStimulus(8'h5A, 8'h3C, waitsA);
    waitResult(cyc);
    checkOutput("a latency", cyc, 32'd9);
    checkOutput("a sum/carry", {23'b0, c8, s8}, 32'h096);
    tick();
    checkOutput("a back to idle", {31'b0, r8}, 32'd1);

    // (b) overflow
    applyStimulus(8'hFF, 8'h01, waitsA);
    waitResult(cyc);
    checkOutput("b sum/carry", {23'b0, c8, s8}, 32'h100);
    tick();

    // (c) backpressure hold
    or8 = 1'b0;
    applyStimulus(8'hFF, 8'hFF, waitsA);
    waitResult(cyc);
    for (int i = 0; i < 5; i++) begin
      checkOutput("c held valid", {31'b0, ov8}, 32'd1);
      checkOutput("c held sum/carry", {23'b0, c8, s8}, 32'h1FE);
      tick();
    end
    or8 = 1'b1;
    tick();
    checkOutput("c in_ready after consume", {31'b0, r8}, 32'd1);
    checkOutput("c out_valid after consume", {31'b0, ov8}, 32'd0);

    // (d) in_valid during ADD ignored
    applyStimulus(8'h01, 8'h02, waitsA);
    tick(); tick();
    v8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    checkOutput("d in_ready in ADD", {31'b0, r8}, 32'd0);
    tick();
    v8 = 1'b0;
    waitResult(cyc);
    checkOutput("d sum/carry", {23'b0, c8, s8}, 32'h003);
    tick(); tick();
    checkOutput("d no capture", {31'b0, busy8}, 32'd0);

    // (e) reset mid-ADD, then accept on first edge after reset
    applyStimulus(8'h33, 8'h44, waitsA);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("e flags after reset", {29'b0, ov8, busy8, r8}, 32'd1);
    checkOutput("e sum/carry after reset", {23'b0, c8, s8}, 32'd0);
    applyStimulus(8'h80, 8'h80, waitsA);
    checkOutput("e immediate accept", waitsA, 32'd0);
    waitResult(cyc);
    checkOutput("e sum/carry", {23'b0, c8, s8}, 32'h100);
    tick();

    // (f) back-to-back with in_valid held high
    v8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    checkOutput("f first ready", {31'b0, r8}, 32'd1);
    tick();
    a8 = 8'h56; b8 = 8'h78;
    waitResult(cyc);
    checkOutput("f first sum", {23'b0, c8, s8}, 32'h046);
    tick();
    checkOutput("f bubble idle", {30'b0, r8, busy8}, 32'd2);
    tick();
    checkOutput("f second accepted", {31'b0, busy8}, 32'd1);
    v8 = 1'b0;
    waitResult(cyc);
    checkOutput("f second sum", {23'b0, c8, s8}, 32'h0CE);
    tick();

    // Randomized traffic on both widths
    randMode = 1'b1;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          if ($urandom_range(0, 3) == 0) tick();
          applyStimulus(8'($urandom), 8'($urandom), waitsA);
        end
      end
      begin
        for (int n = 0; n < 1000; n++) begin
          if ($urandom_range(0, 3) == 0) tick();
          applyStimulus1(1'($urandom), 1'($urandom), waitsB);
        end
      end
    join
    randMode = 1'b0;
    tick();
    or8 = 1'b1; or1 = 1'b1;
    repeat (30) tick();
    checkOutput("w8 queue drained", exp8Q.size(), 32'd0);
    checkOutput("w1 queue drained", exp1Q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
